ft_frame_sequencer: RTL and testbench

//  Sequences the FT2232H synchronous-FIFO read path and frames the depth byte stream.
//  - Drives the FT2232H read handshake (oe_n, rd_n).
//  - Hunts for the DD,CC,BB,AA sync header and pairs bytes into 16-bit pixels.
//  - Issues indexed pixel strobes plus capture/update mode to the background-memory and threshold logic.
//  - Flags frame completion and stream errors.

---
 rtl/ft_seq_pkg.sv | 25 ++
 rtl/ft_fifo_reader.sv | 66 ++++++
 rtl/ft_frame_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_ft_frame_sequencer.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft_seq_pkg.sv
// Shared constants and state encodings for the FT2232H frame sequencer.
package ft_seq_pkg;

    localparam logic [7:0] SYNC0 = 8'hDD;
    localparam logic [7:0] SYNC1 = 8'hCC;
    localparam logic [7:0] SYNC2 = 8'hBB;
    localparam logic [7:0] SYNC3 = 8'hAA;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        PIX_HI = 2'd1,
        PIX_LO = 2'd2
    } frame_state_e;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_OE     = 2'd1,
        RD_ACTIVE = 2'd2
    } rd_state_e;

    function automatic int unsigned num_pixels(input int unsigned width, input int unsigned height);
        return width * height;
    endfunction

endpackage

// File: rtl/ft_fifo_reader.sv
// FT2232H synchronous-FIFO read handshake: asserts oe_n, then rd_n, while rxf_n stays low.
module ft_fifo_reader
    import ft_seq_pkg::*;
(
    input  logic       clock_60_mhz,
    input  logic       reset,
    input  logic       rxf_n,
    input  logic [7:0] data,
    output logic       oe_n,
    output logic       rd_n,
    output logic       byte_vld,
    output logic [7:0] byte_data
);

    rd_state_e state_q, state_d;
    logic      oe_n_q, oe_n_d;
    logic      rd_n_q, rd_n_d;

    always_comb begin
        state_d = state_q;
        oe_n_d  = oe_n_q;
        rd_n_d  = rd_n_q;
        if (rxf_n) begin
            state_d = RD_IDLE;
            oe_n_d  = 1'b1;
            rd_n_d  = 1'b1;
        end else begin
            unique case (state_q)
                RD_IDLE: begin
                    state_d = RD_OE;
                    oe_n_d  = 1'b0;
                end
                RD_OE: begin
                    state_d = RD_ACTIVE;
                    rd_n_d  = 1'b0;
                end
                RD_ACTIVE: begin
                end
                default: begin
                    state_d = RD_IDLE;
                    oe_n_d  = 1'b1;
                    rd_n_d  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock_60_mhz) begin
        if (reset) begin
            state_q <= RD_IDLE;
            oe_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            oe_n_q  <= oe_n_d;
            rd_n_q  <= rd_n_d;
        end
    end

    // The chip hands over a byte on every edge where our registered strobe and its rxf_n are both low.
    assign byte_vld  = ~rd_n_q & ~rxf_n;
    assign byte_data = data;
    assign oe_n      = oe_n_q;
    assign rd_n      = rd_n_q;

endmodule

// File: rtl/ft_frame_sequencer.sv
// Frames the FT2232H depth byte stream into indexed 16-bit pixels after a DD,CC,BB,AA header.
// Optional FT_SEQ_RESYNC_EN: header matching also mid-frame, restarting the frame and pulsing err_short.
module ft_frame_sequencer
    import ft_seq_pkg::*;
#(
    parameter int WIDTH       = 512,
    parameter int HEIGHT      = 424,
    parameter int LOGSIZE     = 18,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic               clock_60_mhz,
    input  logic               reset,
    input  logic               rxf_n,
    input  logic [7:0]         data,
    input  logic               capture_req,
    output logic               oe_n,
    output logic               rd_n,
    output logic               pix_valid,
    output logic [15:0]        pix_data,
    output logic [LOGSIZE-1:0] pix_index,
    output logic               pix_capture,
    output logic               frame_start,
    output logic               frame_done,
    output logic               busy,
    output logic               err_timeout,
    output logic               err_short,
    output logic [7:0]         frame_count
);

    localparam int unsigned        NPIX     = num_pixels(WIDTH, HEIGHT);
    localparam logic [LOGSIZE-1:0] LAST_IDX = LOGSIZE'(NPIX - 1);
    localparam int                 TW       = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYC - 1);
`ifdef FT_SEQ_RESYNC_EN
    localparam bit RESYNC_EN = 1'b1;
`else
    localparam bit RESYNC_EN = 1'b0;
`endif

    logic       byte_vld;
    logic [7:0] byte_data;

    ft_fifo_reader u_reader (
        .clock_60_mhz (clock_60_mhz),
        .reset        (reset),
        .rxf_n        (rxf_n),
        .data         (data),
        .oe_n         (oe_n),
        .rd_n         (rd_n),
        .byte_vld     (byte_vld),
        .byte_data    (byte_data)
    );

    frame_state_e       state_q, state_d;
    logic [23:0]        sync_q, sync_d;
    logic [7:0]         hi_q, hi_d;
    logic [LOGSIZE-1:0] idx_q, idx_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic               pix_valid_q, pix_valid_d;
    logic [15:0]        pix_data_q, pix_data_d;
    logic [LOGSIZE-1:0] pix_index_q, pix_index_d;
    logic               pix_capture_q, pix_capture_d;
    logic               frame_start_q, frame_start_d;
    logic               frame_done_q, frame_done_d;
    logic               busy_q, busy_d;
    logic               err_timeout_q, err_timeout_d;
    logic [7:0]         frame_count_q, frame_count_d;
`ifdef FT_SEQ_RESYNC_EN
    logic               err_short_q, err_short_d;
`endif

    logic matcher_on;
    logic header_hit;

    // Without resync the matcher is frozen during a frame, so header-like pixel bytes stay pixels.
    assign matcher_on = (state_q == HUNT) || RESYNC_EN;
    assign header_hit = ({sync_q, byte_data} == {SYNC0, SYNC1, SYNC2, SYNC3});

    always_comb begin
        state_d       = state_q;
        sync_d        = sync_q;
        hi_d          = hi_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        pix_valid_d   = 1'b0;
        pix_data_d    = pix_data_q;
        pix_index_d   = pix_index_q;
        pix_capture_d = pix_capture_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        busy_d        = busy_q;
        err_timeout_d = 1'b0;
        frame_count_d = frame_count_q;
`ifdef FT_SEQ_RESYNC_EN
        err_short_d   = 1'b0;
`endif

        if (byte_vld && matcher_on) begin
            sync_d = {sync_q[15:0], byte_data};
        end

        if (byte_vld && matcher_on && header_hit) begin
            // Header bytes are flushed from the matcher so they can never pair into pixels.
            state_d       = PIX_HI;
            sync_d        = '0;
            idx_d         = '0;
            tmo_d         = '0;
            frame_start_d = 1'b1;
            busy_d        = 1'b1;
            pix_capture_d = capture_req;
`ifdef FT_SEQ_RESYNC_EN
            err_short_d   = (state_q != HUNT);
`endif
        end else if (byte_vld) begin
            tmo_d = '0;
            unique case (state_q)
                HUNT: begin
                end
                PIX_HI: begin
                    hi_d    = byte_data;
                    state_d = PIX_LO;
                end
                PIX_LO: begin
                    pix_valid_d = 1'b1;
                    pix_data_d  = {hi_q, byte_data};
                    pix_index_d = idx_q;
                    state_d     = PIX_HI;
                    if (idx_q == LAST_IDX) begin
                        frame_done_d  = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                        busy_d        = 1'b0;
                        idx_d         = '0;
                        state_d       = HUNT;
                    end else begin
                        idx_d = idx_q + LOGSIZE'(1);
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (state_q != HUNT) begin
            // A stalled mid-frame stream drops any half pixel and goes back to hunting.
            if (tmo_q == TMO_LAST) begin
                err_timeout_d = 1'b1;
                busy_d        = 1'b0;
                idx_d         = '0;
                tmo_d         = '0;
                state_d       = HUNT;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clock_60_mhz) begin
        if (reset) begin
            state_q       <= HUNT;
            sync_q        <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            pix_valid_q   <= 1'b0;
            pix_data_q    <= '0;
            pix_index_q   <= '0;
            pix_capture_q <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            err_timeout_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sync_q        <= sync_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            pix_valid_q   <= pix_valid_d;
            pix_data_q    <= pix_data_d;
            pix_index_q   <= pix_index_d;
            pix_capture_q <= pix_capture_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
            busy_q        <= busy_d;
            err_timeout_q <= err_timeout_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_ff @(posedge clock_60_mhz) begin
        hi_q <= hi_d;
    end

`ifdef FT_SEQ_RESYNC_EN
    always_ff @(posedge clock_60_mhz) begin
        if (reset) begin
            err_short_q <= 1'b0;
        end else begin
            err_short_q <= err_short_d;
        end
    end
    assign err_short = err_short_q;
`else
    assign err_short = 1'b0;
`endif

    assign pix_valid   = pix_valid_q;
    assign pix_data    = pix_data_q;
    assign pix_index   = pix_index_q;
    assign pix_capture = pix_capture_q;
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ft_frame_sequencer.sv
// Self-checking bench for ft_frame_sequencer (WIDTH=4, HEIGHT=2, TIMEOUT_CYC=16).
module tb_ft_frame_sequencer;

    localparam int WIDTH       = 4;
    localparam int HEIGHT      = 2;
    localparam int LOGSIZE     = 3;
    localparam int TIMEOUT_CYC = 16;
    localparam int NPIX        = WIDTH * HEIGHT;

    logic               clock_60_mhz = 1'b0;
    logic               reset        = 1'b1;
    logic               rxf_n        = 1'b1;
    logic [7:0]         data         = 8'h00;
    logic               capture_req  = 1'b0;
    logic               oe_n, rd_n, pix_valid, pix_capture;
    logic [15:0]        pix_data;
    logic [LOGSIZE-1:0] pix_index;
    logic               frame_start, frame_done, busy, err_timeout, err_short;
    logic [7:0]         frame_count;

    ft_frame_sequencer #(
        .WIDTH       (WIDTH),
        .HEIGHT      (HEIGHT),
        .LOGSIZE     (LOGSIZE),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clock_60_mhz (clock_60_mhz),
        .reset        (reset),
        .rxf_n        (rxf_n),
        .data         (data),
        .capture_req  (capture_req),
        .oe_n         (oe_n),
        .rd_n         (rd_n),
        .pix_valid    (pix_valid),
        .pix_data     (pix_data),
        .pix_index    (pix_index),
        .pix_capture  (pix_capture),
        .frame_start  (frame_start),
        .frame_done   (frame_done),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_short    (err_short),
        .frame_count  (frame_count)
    );

    always #5 clock_60_mhz = ~clock_60_mhz;

    int vectors     = 0;
    int miscompares = 0;
    int exp_frames  = 0;

    logic [7:0]  tx_q[$];
    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    int start_cnt = 0;
    int done_cnt  = 0;
    int tmo_cnt   = 0;
    int short_cnt = 0;

    int cap_at   = -1;
    bit cap_val  = 1'b0;
    bit cap_rand = 1'b0;

    // Observed pixels packed as {data, 3'b0, index, capture, done}.
    always @(negedge clock_60_mhz) begin
        if (pix_valid) obs_q.push_back({pix_data, 3'b000, pix_index, pix_capture, frame_done});
        if (frame_start) start_cnt++;
        if (frame_done)  done_cnt++;
        if (err_timeout) tmo_cnt++;
        if (err_short)   short_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_header();
        tx_q.push_back(8'hDD);
        tx_q.push_back(8'hCC);
        tx_q.push_back(8'hBB);
        tx_q.push_back(8'hAA);
    endtask

    // Reference: first header in the stream, then consecutive byte pairs up to one frame.
    task automatic model_frame(input bit cap);
        int j;
        int npairs;
        j = -1;
        exp_q.delete();
        for (int k = 0; k + 3 < tx_q.size(); k++)
            if (j < 0 && tx_q[k] == 8'hDD && tx_q[k+1] == 8'hCC && tx_q[k+2] == 8'hBB && tx_q[k+3] == 8'hAA)
                j = k;
        if (j >= 0) begin
            npairs = (tx_q.size() - j - 4) / 2;
            if (npairs > NPIX) npairs = NPIX;
            for (int p = 0; p < npairs; p++)
                exp_q.push_back({tx_q[j+4+2*p], tx_q[j+5+2*p], 6'(p), cap, p == NPIX - 1});
            if (npairs == NPIX) exp_frames++;
        end
    endtask

    // Plays tx_q like an FT2232H: present a byte with rxf_n low until the DUT strobes it in.
    task automatic send_stream(input int max_gap);
        int  budget;
        bit  acc;
        for (int i = 0; i < tx_q.size(); i++) begin
            if (max_gap > 0 && $urandom_range(0, 3) == 0) begin
                rxf_n = 1'b1;
                repeat ($urandom_range(1, max_gap)) begin
                    @(posedge clock_60_mhz); #1;
                end
            end
            data        = tx_q[i];
            rxf_n       = 1'b0;
            capture_req = (i == cap_at) ? cap_val : (cap_rand ? 1'($urandom_range(0, 1)) : 1'b0);
            acc         = 1'b0;
            budget      = 0;
            while (!acc) begin
                acc = (rd_n == 1'b0);
                @(posedge clock_60_mhz); #1;
                budget++;
                if (!acc && budget > 20) begin
                    miscompares++;
                    vectors++;
                    $display("FAIL send_timeout byte %0d actual=not_read required=read_within_20", i);
                    rxf_n = 1'b1;
                    return;
                end
            end
        end
        rxf_n       = 1'b1;
        capture_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin @(posedge clock_60_mhz); #1; end
        vectors++;
        if ({oe_n, rd_n, pix_valid, frame_start, frame_done, busy, err_timeout, err_short, pix_capture} !== 9'b110000000) begin
            miscompares++;
            $display("FAIL reset_ctrl actual=%b required=110000000",
                {oe_n, rd_n, pix_valid, frame_start, frame_done, busy, err_timeout, err_short, pix_capture});
        end
        vectors++;
        if ({pix_data, 5'b0, pix_index, frame_count} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_data actual=%h/%h/%h required=0/0/0", pix_data, pix_index, frame_count);
        end
        reset = 1'b0;
        @(posedge clock_60_mhz); #1;
    endtask

    task automatic test_handshake();
        rxf_n = 1'b0;
        @(posedge clock_60_mhz); #1;
        vectors++;
        if ({oe_n, rd_n} !== 2'b01) begin
            miscompares++;
            $display("FAIL hs_cycle1 actual=%b required=01", {oe_n, rd_n});
        end
        @(posedge clock_60_mhz); #1;
        vectors++;
        if ({oe_n, rd_n} !== 2'b00) begin
            miscompares++;
            $display("FAIL hs_cycle2 actual=%b required=00", {oe_n, rd_n});
        end
        rxf_n = 1'b1;
        @(posedge clock_60_mhz); #1;
        vectors++;
        if ({oe_n, rd_n} !== 2'b11) begin
            miscompares++;
            $display("FAIL hs_release actual=%b required=11", {oe_n, rd_n});
        end
        repeat (2) begin @(posedge clock_60_mhz); #1; end
    endtask

    task automatic test_frame();
        int base, s0, d0;
        tx_q.delete();
        push_header();
        for (int b = 0; b < 16; b++) tx_q.push_back(8'(b));
        cap_at = -1; cap_rand = 1'b0;
        base = obs_q.size(); s0 = start_cnt; d0 = done_cnt;
        model_frame(1'b0);
        send_stream(0);
        repeat (3) begin @(posedge clock_60_mhz); #1; end
        vectors++;
        if (obs_q.size() - base !== exp_q.size()) begin
            miscompares++;
            $display("FAIL frame_count_pix actual=%0d required=%0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[base+i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL frame_pix[%0d] actual=%h required=%h", i, obs_q[base+i], exp_q[i]);
            end
        end
        vectors++;
        if ({start_cnt - s0, done_cnt - d0} !== {32'd1, 32'd1}) begin
            miscompares++;
            $display("FAIL frame_pulses actual=start%0d/done%0d required=1/1", start_cnt - s0, done_cnt - d0);
        end
        vectors++;
        if ({busy, frame_count} !== {1'b0, 8'(exp_frames)}) begin
            miscompares++;
            $display("FAIL frame_cnt actual=busy%b/%0d required=0/%0d", busy, frame_count, exp_frames);
        end
    endtask

    task automatic test_capture();
        int base;
        for (int f = 0; f < 2; f++) begin
            tx_q.delete();
            push_header();
            for (int b = 0; b < 16; b++) tx_q.push_back(8'($urandom_range(0, 255)));
            cap_at = 3; cap_val = (f == 0); cap_rand = 1'b0;
            base = obs_q.size();
            model_frame(f == 0);
            send_stream(0);
            repeat (3) begin @(posedge clock_60_mhz); #1; end
            vectors++;
            if (obs_q.size() - base !== exp_q.size()) begin
                miscompares++;
                $display("FAIL capture%0d_count actual=%0d required=%0d", f, obs_q.size() - base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
                vectors++;
                if (obs_q[base+i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL capture%0d_pix[%0d] actual=%h required=%h", f, i, obs_q[base+i], exp_q[i]);
                end
            end
        end
        vectors++;
        if (frame_count !== 8'(exp_frames)) begin
            miscompares++;
            $display("FAIL capture_frames actual=%0d required=%0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_random();
        int base, ngarb;
        for (int f = 0; f < 6; f++) begin
            tx_q.delete();
            ngarb = $urandom_range(0, 6);
            for (int g = 0; g < ngarb; g++) tx_q.push_back(8'($urandom_range(0, 169)));
            push_header();
`ifdef FT_SEQ_RESYNC_EN
            for (int b = 0; b < 16; b++) tx_q.push_back(8'($urandom_range(0, 169)));
`else
            for (int b = 0; b < 16; b++) tx_q.push_back(8'($urandom_range(0, 255)));
`endif
            cap_at = ngarb + 3; cap_val = 1'($urandom_range(0, 1)); cap_rand = 1'b1;
            base = obs_q.size();
            model_frame(cap_val);
            send_stream(3);
            repeat (3) begin @(posedge clock_60_mhz); #1; end
            vectors++;
            if (obs_q.size() - base !== exp_q.size()) begin
                miscompares++;
                $display("FAIL random%0d_count actual=%0d required=%0d", f, obs_q.size() - base, exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
                vectors++;
                if (obs_q[base+i] !== exp_q[i]) begin
                    miscompares++;
                    $display("FAIL random%0d_pix[%0d] actual=%h required=%h", f, i, obs_q[base+i], exp_q[i]);
                end
            end
            vectors++;
            if (frame_count !== 8'(exp_frames)) begin
                miscompares++;
                $display("FAIL random%0d_frames actual=%0d required=%0d", f, frame_count, exp_frames);
            end
        end
        cap_rand = 1'b0; cap_at = -1;
    endtask

    task automatic test_timeout();
        int base, d0, first, pulses;
        logic busy_mid;
        tx_q.delete();
        push_header();
        for (int b = 0; b < 5; b++) tx_q.push_back(8'(8'h10 + b));
        cap_at = -1; cap_rand = 1'b0;
        base = obs_q.size(); d0 = done_cnt;
        model_frame(1'b0);
        send_stream(0);
        first = -1; pulses = 0; busy_mid = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clock_60_mhz); #1;
            if (err_timeout) begin
                pulses++;
                if (first < 0) first = n;
            end
            if (n == 15) busy_mid = busy;
        end
        vectors++;
        if (first !== 16 || pulses !== 1) begin
            miscompares++;
            $display("FAIL timeout_pulse actual=cycle%0d/x%0d required=cycle16/x1", first, pulses);
        end
        vectors++;
        if ({busy_mid, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_busy actual=%b required=10", {busy_mid, busy});
        end
        vectors++;
        if (obs_q.size() - base !== exp_q.size()) begin
            miscompares++;
            $display("FAIL timeout_count actual=%0d required=%0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[base+i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL timeout_pix[%0d] actual=%h required=%h", i, obs_q[base+i], exp_q[i]);
            end
        end
        vectors++;
        if ({done_cnt - d0, 24'(frame_count)} !== {32'd0, 24'(8'(exp_frames))}) begin
            miscompares++;
            $display("FAIL timeout_done actual=%0d/%0d required=0/%0d", done_cnt - d0, frame_count, exp_frames);
        end
    endtask

    task automatic test_resync();
        int base, s0, sh0;
        tx_q.delete();
        push_header();
        for (int b = 0; b < 6; b++) tx_q.push_back(8'(b));
        push_header();
`ifdef FT_SEQ_RESYNC_EN
        for (int b = 0; b < 16; b++) tx_q.push_back(8'(8'h10 + b));
        exp_q.delete();
        exp_q.push_back({8'h00, 8'h01, 6'd0, 1'b0, 1'b0});
        exp_q.push_back({8'h02, 8'h03, 6'd1, 1'b0, 1'b0});
        exp_q.push_back({8'h04, 8'h05, 6'd2, 1'b0, 1'b0});
        exp_q.push_back({8'hDD, 8'hCC, 6'd3, 1'b0, 1'b0});
        for (int p = 0; p < NPIX; p++)
            exp_q.push_back({8'(8'h10 + 2*p), 8'(8'h11 + 2*p), 6'(p), 1'b0, p == NPIX - 1});
        exp_frames++;
`else
        for (int b = 0; b < 6; b++) tx_q.push_back(8'(8'h06 + b));
        model_frame(1'b0);
`endif
        cap_at = -1; cap_rand = 1'b0;
        base = obs_q.size(); s0 = start_cnt; sh0 = short_cnt;
        send_stream(0);
        repeat (3) begin @(posedge clock_60_mhz); #1; end
        vectors++;
        if (obs_q.size() - base !== exp_q.size()) begin
            miscompares++;
            $display("FAIL resync_count actual=%0d required=%0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[base+i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL resync_pix[%0d] actual=%h required=%h", i, obs_q[base+i], exp_q[i]);
            end
        end
        vectors++;
`ifdef FT_SEQ_RESYNC_EN
        if ({start_cnt - s0, short_cnt - sh0} !== {32'd2, 32'd1}) begin
            miscompares++;
            $display("FAIL resync_pulses actual=start%0d/short%0d required=2/1", start_cnt - s0, short_cnt - sh0);
        end
`else
        if ({start_cnt - s0, short_cnt - sh0} !== {32'd1, 32'd0}) begin
            miscompares++;
            $display("FAIL resync_pulses actual=start%0d/short%0d required=1/0", start_cnt - s0, short_cnt - sh0);
        end
`endif
        vectors++;
        if (frame_count !== 8'(exp_frames)) begin
            miscompares++;
            $display("FAIL resync_frames actual=%0d required=%0d", frame_count, exp_frames);
        end
    endtask

    task automatic test_reset_midframe();
        int base, d0, t0;
        tx_q.delete();
        push_header();
        for (int b = 0; b < 9; b++) tx_q.push_back(8'(8'h40 + b));
        cap_at = 3; cap_val = 1'b1; cap_rand = 1'b0;
        d0 = done_cnt; t0 = tmo_cnt;
        send_stream(0);
        reset = 1'b1;
        @(posedge clock_60_mhz); #1;
        vectors++;
        if ({oe_n, rd_n, pix_valid, frame_start, frame_done, busy, err_timeout, err_short, pix_capture} !== 9'b110000000) begin
            miscompares++;
            $display("FAIL midreset_ctrl actual=%b required=110000000",
                {oe_n, rd_n, pix_valid, frame_start, frame_done, busy, err_timeout, err_short, pix_capture});
        end
        vectors++;
        if ({pix_data, 5'b0, pix_index, frame_count} !== 32'h0) begin
            miscompares++;
            $display("FAIL midreset_data actual=%h/%h/%h required=0/0/0", pix_data, pix_index, frame_count);
        end
        reset = 1'b0;
        exp_frames = 0;
        repeat (2) begin @(posedge clock_60_mhz); #1; end
        vectors++;
        if ({done_cnt - d0, tmo_cnt - t0} !== {32'd0, 32'd0}) begin
            miscompares++;
            $display("FAIL midreset_pulses actual=done%0d/tmo%0d required=0/0", done_cnt - d0, tmo_cnt - t0);
        end
        tx_q.delete();
        push_header();
        for (int b = 0; b < 16; b++) tx_q.push_back(8'($urandom_range(0, 255)));
        cap_at = -1;
        base = obs_q.size();
        model_frame(1'b0);
        send_stream(2);
        repeat (3) begin @(posedge clock_60_mhz); #1; end
        vectors++;
        if (obs_q.size() - base !== exp_q.size()) begin
            miscompares++;
            $display("FAIL after_reset_count actual=%0d required=%0d", obs_q.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[base+i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL after_reset_pix[%0d] actual=%h required=%h", i, obs_q[base+i], exp_q[i]);
            end
        end
        vectors++;
        if (frame_count !== 8'(exp_frames)) begin
            miscompares++;
            $display("FAIL after_reset_frames actual=%0d required=%0d", frame_count, exp_frames);
        end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_frame();
        test_capture();
        test_random();
        test_timeout();
        test_resync();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
